// File: rtl/rz_pkg.sv
// Shared types, constants and helpers for the multi-channel ARINC429 RZ receiver.
package rz_pkg;
    localparam int WORD_BITS = 32;
    localparam int ERR_PAR   = 0;
    localparam int ERR_LEN   = 1;
    localparam int ERR_ILL   = 2;
    localparam int ERR_W     = 3;

    typedef enum logic [1:0] {
        LS_NULL = 2'd0,
        LS_ONE  = 2'd1,
        LS_ZERO = 2'd2,
        LS_ILL  = 2'd3
    } line_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RX       = 2'd1,
        ST_CHECK    = 2'd2,
        ST_WAIT_GAP = 2'd3
    } dec_st_t;

    function automatic line_t decode_line(input logic a, input logic b);
        line_t ls;
        case ({a, b})
            2'b10:   ls = LS_ONE;
            2'b01:   ls = LS_ZERO;
            2'b00:   ls = LS_NULL;
            default: ls = LS_ILL;
        endcase
        return ls;
    endfunction

    // ARINC words carry odd parity over all 32 bits.
    function automatic logic odd_parity_ok(input logic [WORD_BITS-1:0] w);
        return ^w;
    endfunction
endpackage

// File: rtl/rz_rx_chan.sv
// One ARINC429 receive channel: line sync, debounce, word decoder, checks and
// a circular DEPTH x 32 word buffer with an asynchronous read port.
module rz_rx_chan
    import rz_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int DEB       = 2,
    parameter int GAP       = 12,
    parameter int STORE_BAD = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       tick,
    input  logic                       line_a,
    input  logic                       line_b,
    input  logic                       err_clr,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [WORD_BITS-1:0]       rd_word,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic                       word_strb,
    output logic [ERR_W-1:0]           err_flags
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(GAP + 1);
    localparam logic [GW-1:0] GAP_C = GW'(GAP);
    localparam logic [2:0]    DEB_C = 3'(DEB);

    logic [1:0]           a_sync_q, b_sync_q;
    dec_st_t              state_q, state_d;
    logic [5:0]           bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0] word_q, word_d;
    logic                 armed_q, armed_d;
    logic [2:0]           deb_cnt_q, deb_cnt_d;
    logic                 deb_val_q, deb_val_d;
    logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
    logic                 strb_q, strb_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [ERR_W-1:0]     err_q, err_d, err_set_s;
    logic [WORD_BITS-1:0] mem_q [DEPTH];
    line_t                ls_s;
    logic                 accept_s, ill_s, gap_hit_s;

    assign ls_s = decode_line(a_sync_q[1], b_sync_q[1]);

    // Two-stage synchronizers on both line legs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_sync_q <= 2'b00;
            b_sync_q <= 2'b00;
        end else begin
            a_sync_q <= {a_sync_q[0], line_a};
            b_sync_q <= {b_sync_q[0], line_b};
        end
    end

    // Debounce and NULL-gap counting; a bit is taken once per NULL-separated pulse.
    always_comb begin
        armed_d   = armed_q;
        deb_cnt_d = deb_cnt_q;
        deb_val_d = deb_val_q;
        gap_cnt_d = gap_cnt_q;
        accept_s  = 1'b0;
        ill_s     = 1'b0;
        gap_hit_s = 1'b0;
        if (tick) begin
            case (ls_s)
                LS_NULL: begin
                    armed_d   = 1'b1;
                    deb_cnt_d = 3'd0;
                    if (gap_cnt_q != GAP_C) begin
                        gap_cnt_d = gap_cnt_q + {{(GW-1){1'b0}}, 1'b1};
                    end else begin
                        gap_cnt_d = gap_cnt_q;
                    end
                    gap_hit_s = (gap_cnt_d == GAP_C);
                end
                LS_ONE, LS_ZERO: begin
                    gap_cnt_d = '0;
                    if (armed_q) begin
                        if ((deb_cnt_q != 3'd0) && (deb_val_q == (ls_s == LS_ONE))) begin
                            deb_cnt_d = deb_cnt_q + 3'd1;
                        end else begin
                            deb_cnt_d = 3'd1;
                            deb_val_d = (ls_s == LS_ONE);
                        end
                        if (deb_cnt_d == DEB_C) begin
                            accept_s  = 1'b1;
                            armed_d   = 1'b0;
                            deb_cnt_d = 3'd0;
                        end else begin
                            accept_s  = 1'b0;
                        end
                    end else begin
                        deb_cnt_d = 3'd0;
                    end
                end
                default: begin
                    ill_s     = 1'b1;
                    armed_d   = 1'b0;
                    deb_cnt_d = 3'd0;
                    gap_cnt_d = '0;
                end
            endcase
        end else begin
            accept_s = 1'b0;
        end
    end

    // Decoder next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_RX;
                else          state_d = ST_IDLE;
            end
            ST_RX: begin
                if (ill_s)                                  state_d = ST_WAIT_GAP;
                else if (accept_s && (bit_cnt_q == 6'd31)) state_d = ST_CHECK;
                else if (gap_hit_s)                         state_d = ST_IDLE;
                else                                        state_d = ST_RX;
            end
            ST_CHECK: state_d = ST_WAIT_GAP;
            ST_WAIT_GAP: begin
                if (gap_hit_s) state_d = ST_IDLE;
                else           state_d = ST_WAIT_GAP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Word assembly, store decision, pointer and sticky error updates.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        word_d    = word_q;
        err_set_s = '0;
        strb_d    = 1'b0;
        if (strb_q) wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        else        wr_ptr_d = wr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (ill_s) begin
                    err_set_s[ERR_ILL] = 1'b1;
                end else if (accept_s) begin
                    word_d    = '0;
                    word_d[0] = deb_val_d;
                    bit_cnt_d = 6'd1;
                end else begin
                    bit_cnt_d = 6'd0;
                end
            end
            ST_RX: begin
                if (ill_s) begin
                    err_set_s[ERR_ILL] = 1'b1;
                    bit_cnt_d          = 6'd0;
                end else if (accept_s) begin
                    word_d[bit_cnt_q[4:0]] = deb_val_d;
                    bit_cnt_d              = bit_cnt_q + 6'd1;
                    // Strobe is registered so it lines up with the CHECK-cycle write.
                    if (bit_cnt_q == 6'd31) strb_d = odd_parity_ok(word_d) || (STORE_BAD != 0);
                    else                    strb_d = 1'b0;
                end else if (gap_hit_s) begin
                    err_set_s[ERR_LEN] = 1'b1;
                    bit_cnt_d          = 6'd0;
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            ST_CHECK: begin
                bit_cnt_d = 6'd0;
                if (!odd_parity_ok(word_q)) err_set_s[ERR_PAR] = 1'b1;
                else                        err_set_s[ERR_PAR] = 1'b0;
                if (ill_s) err_set_s[ERR_ILL] = 1'b1;
                else       err_set_s[ERR_ILL] = 1'b0;
            end
            ST_WAIT_GAP: begin
                bit_cnt_d = 6'd0;
                if (ill_s)         err_set_s[ERR_ILL] = 1'b1;
                else if (accept_s) err_set_s[ERR_LEN] = 1'b1;
                else               err_set_s          = '0;
            end
            default: bit_cnt_d = 6'd0;
        endcase
        err_d = err_set_s | (err_q & {ERR_W{~err_clr}});
    end

    // Decoder state and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 6'd0;
            word_q    <= '0;
            armed_q   <= 1'b0;
            deb_cnt_q <= 3'd0;
            deb_val_q <= 1'b0;
            gap_cnt_q <= '0;
            strb_q    <= 1'b0;
            wr_ptr_q  <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            word_q    <= word_d;
            armed_q   <= armed_d;
            deb_cnt_q <= deb_cnt_d;
            deb_val_q <= deb_val_d;
            gap_cnt_q <= gap_cnt_d;
            strb_q    <= strb_d;
            wr_ptr_q  <= wr_ptr_d;
            err_q     <= err_d;
        end
    end

    // Word buffer write; contents intentionally survive reset.
    always_ff @(posedge clock) begin
        if (strb_q) mem_q[wr_ptr_q] <= word_q;
    end

    assign rd_word   = mem_q[rd_idx];
    assign wr_ptr    = wr_ptr_q;
    assign word_strb = strb_q;
    assign err_flags = err_q;
endmodule

// File: rtl/rz_rx_multi.sv
// N-channel ARINC429 receiver bank: shared sample-tick detect, per-channel
// receivers and one registered 16-bit host read port.
module rz_rx_multi
    import rz_pkg::*;
#(
    parameter int NUM_CH    = 6,
    parameter int DEPTH     = 16,
    parameter int DEB       = 2,
    parameter int GAP       = 12,
    parameter int STORE_BAD = 0
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  inp_clk,
    input  logic [NUM_CH-1:0]                     line_A,
    input  logic [NUM_CH-1:0]                     line_B,
    input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] rd_ch,
    input  logic [$clog2(DEPTH):0]                rd_addr,
    output logic [15:0]                           rd_data,
    output logic [NUM_CH*$clog2(DEPTH)-1:0]       wr_ptr,
    output logic [NUM_CH-1:0]                     word_strb,
    output logic [NUM_CH*ERR_W-1:0]               err_flags,
    input  logic [NUM_CH-1:0]                     err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CW:0] NCH_C = (CW + 1)'(NUM_CH);

    logic [1:0]           inp_sync_q;
    logic                 inp_prev_q;
    logic                 tick_q, tick_d;
    logic [15:0]          rd_data_q, rd_data_d;
    logic [WORD_BITS-1:0] chan_word_s [NUM_CH];
    logic [WORD_BITS-1:0] sel_word_s;

    assign tick_d = inp_sync_q[1] & ~inp_prev_q;

    // Sample-strobe synchronizer and rising-edge tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inp_sync_q <= 2'b00;
            inp_prev_q <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            inp_sync_q <= {inp_sync_q[0], inp_clk};
            inp_prev_q <= inp_sync_q[1];
            tick_q     <= tick_d;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        rz_rx_chan #(
            .DEPTH    (DEPTH),
            .DEB      (DEB),
            .GAP      (GAP),
            .STORE_BAD(STORE_BAD)
        ) u_chan (
            .clock    (clock),
            .reset    (reset),
            .tick     (tick_q),
            .line_a   (line_A[ch]),
            .line_b   (line_B[ch]),
            .err_clr  (err_clr[ch]),
            .rd_idx   (rd_addr[AW:1]),
            .rd_word  (chan_word_s[ch]),
            .wr_ptr   (wr_ptr[ch*AW +: AW]),
            .word_strb(word_strb[ch]),
            .err_flags(err_flags[ch*ERR_W +: ERR_W])
        );
    end

    // Read mux; unpopulated channel numbers read as zero.
    always_comb begin
        sel_word_s = '0;
        rd_data_d  = 16'h0000;
        if ({1'b0, rd_ch} < NCH_C) begin
            sel_word_s = chan_word_s[rd_ch];
            if (rd_addr[0]) rd_data_d = sel_word_s[31:16];
            else            rd_data_d = sel_word_s[15:0];
        end else begin
            rd_data_d = 16'h0000;
        end
    end

    // Registered read data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) rd_data_q <= 16'h0000;
        else       rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
endmodule

// File: tb/tb_rz_rx_multi.sv
// Scoreboard bench for rz_rx_multi: a default instance and a DEPTH=4,
// STORE_BAD=1 instance receive the same line traffic.
module tb_rz_rx_multi;
    localparam int NCH = 6;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        inp_clk = 1'b0;
    logic [5:0]  line_a = 6'd0, line_b = 6'd0, err_clr = 6'd0;
    logic [2:0]  rd_ch = 3'd0;
    logic [4:0]  rd_addr0 = 5'd0;
    logic [2:0]  rd_addr1 = 3'd0;
    logic [15:0] rd_data0, rd_data1;
    logic [23:0] wr_ptr0;
    logic [11:0] wr_ptr1;
    logic [5:0]  strb0, strb1;
    logic [17:0] err0, err1;

    int n_vec = 0;
    int n_bad = 0;
    int exp_ptr0 [NCH];
    int exp_ptr1 [NCH];
    int q0 [$];
    int q1 [$];
    logic [31:0] tx_word [NCH];

    rz_rx_multi dut0 (
        .clock(clock), .reset(reset), .inp_clk(inp_clk),
        .line_A(line_a), .line_B(line_b), .rd_ch(rd_ch), .rd_addr(rd_addr0),
        .rd_data(rd_data0), .wr_ptr(wr_ptr0), .word_strb(strb0),
        .err_flags(err0), .err_clr(err_clr)
    );

    rz_rx_multi #(.DEPTH(4), .STORE_BAD(1)) dut1 (
        .clock(clock), .reset(reset), .inp_clk(inp_clk),
        .line_A(line_a), .line_B(line_b), .rd_ch(rd_ch), .rd_addr(rd_addr1),
        .rd_data(rd_data1), .wr_ptr(wr_ptr1), .word_strb(strb1),
        .err_flags(err1), .err_clr(err_clr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ef(input int ch, input logic [2:0] bits);
        return 32'(bits) << (3 * ch);
    endfunction

    // Monitors: each strobe must match the next expected {channel, index}.
    always @(negedge clock) begin
        int e;
        for (int c = 0; c < NCH; c++) begin
            if (strb0[c]) begin
                if (q0.size() != 0) e = q0.pop_front();
                else                e = -1;
                chk("dut0 strobe ch/idx", 32'(c * 256 + int'(wr_ptr0[c*4 +: 4])), 32'(e));
            end
        end
    end

    always @(negedge clock) begin
        int e;
        for (int c = 0; c < NCH; c++) begin
            if (strb1[c]) begin
                if (q1.size() != 0) e = q1.pop_front();
                else                e = -1;
                chk("dut1 strobe ch/idx", 32'(c * 256 + int'(wr_ptr1[c*2 +: 2])), 32'(e));
            end
        end
    end

    task automatic do_tick();
        inp_clk = 1'b0; #40;
        inp_clk = 1'b1; #40;
    endtask

    task automatic drive(input logic [5:0] a, input logic [5:0] b, input int n);
        line_a = a;
        line_b = b;
        for (int i = 0; i < n; i++) do_tick();
    endtask

    // Sends nbits of tx_word on masked channels (2 ticks pulse, 2 ticks NULL),
    // optionally followed by a 2-tick ILLEGAL burst, then a NULL gap.
    task automatic send(input logic [5:0] mask, input int nbits, input bit ill, input int gap);
        logic [5:0] a, b;
        if (nbits == 32 && !ill) begin
            for (int c = 0; c < NCH; c++) begin
                if (mask[c]) begin
                    if (^tx_word[c]) begin
                        q0.push_back(c * 256 + exp_ptr0[c]);
                        exp_ptr0[c] = (exp_ptr0[c] + 1) % 16;
                    end
                    q1.push_back(c * 256 + exp_ptr1[c]);
                    exp_ptr1[c] = (exp_ptr1[c] + 1) % 4;
                end
            end
        end
        for (int i = 0; i < nbits; i++) begin
            a = 6'd0;
            b = 6'd0;
            for (int c = 0; c < NCH; c++) begin
                if (mask[c]) begin
                    a[c] = tx_word[c][i];
                    b[c] = ~tx_word[c][i];
                end
            end
            drive(a, b, 2);
            drive(6'd0, 6'd0, 2);
        end
        if (ill) begin
            drive(mask, mask, 2);
            drive(6'd0, 6'd0, 2);
        end
        drive(6'd0, 6'd0, gap);
    endtask

    task automatic rd_chk(input string nm, input bit d, input int ch, input int addr,
                          input logic [15:0] exp);
        rd_ch = 3'(ch);
        if (d) rd_addr1 = 3'(addr);
        else   rd_addr0 = 5'(addr);
        #20;
        chk(nm, d ? 32'(rd_data1) : 32'(rd_data0), 32'(exp));
    endtask

    task automatic chk_ptrs();
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("wr_ptr0[%0d]", c), 32'(wr_ptr0[c*4 +: 4]), 32'(exp_ptr0[c]));
            chk($sformatf("wr_ptr1[%0d]", c), 32'(wr_ptr1[c*2 +: 2]), 32'(exp_ptr1[c]));
        end
    endtask

    task automatic clr(input logic [5:0] mask);
        err_clr = mask;
        #10;
        err_clr = 6'd0;
        #10;
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) begin
            exp_ptr0[c] = 0;
            exp_ptr1[c] = 0;
            tx_word[c]  = 32'd0;
        end
        #52;
        reset = 1'b0;
        chk("reset rd_data0", 32'(rd_data0), 32'd0);
        chk("reset wr_ptr0", 32'(wr_ptr0), 32'd0);
        chk("reset strb0", 32'(strb0), 32'd0);
        chk("reset err0", 32'(err0), 32'd0);
        chk("reset wr_ptr1", 32'(wr_ptr1), 32'd0);
        chk("reset err1", 32'(err1), 32'd0);
        drive(6'd0, 6'd0, 4);

        // Good odd-parity word on channel 0.
        tx_word[0] = 32'h8000_00A5;
        send(6'b000001, 32, 1'b0, 16);
        chk_ptrs();
        chk("t1 err0", 32'(err0), 32'd0);
        rd_chk("t1 ch0 lo", 1'b0, 0, 0, 16'h00A5);
        rd_chk("t1 ch0 hi", 1'b0, 0, 1, 16'h8000);
        rd_chk("t1 dut1 ch0 lo", 1'b1, 0, 0, 16'h00A5);

        // Even-parity word on channel 2: discarded by dut0, kept by dut1.
        tx_word[2] = 32'h0000_00A5;
        send(6'b000100, 32, 1'b0, 16);
        chk_ptrs();
        chk("t2 err0 par", 32'(err0), ef(2, 3'b001));
        chk("t2 err1 par", 32'(err1), ef(2, 3'b001));
        clr(6'b000100);
        chk("t2 err0 clr", 32'(err0), 32'd0);
        chk("t2 err1 clr", 32'(err1), 32'd0);
        rd_chk("t2 dut1 ch2 lo", 1'b1, 2, 0, 16'h00A5);

        // Short word on channel 1, then a good word.
        tx_word[1] = 32'h0001_2345;
        send(6'b000010, 20, 1'b0, 16);
        chk("t3 err0 len", 32'(err0), ef(1, 3'b010));
        chk("t3 err1 len", 32'(err1), ef(1, 3'b010));
        chk_ptrs();
        clr(6'b000010);
        tx_word[1] = 32'h1234_5678;
        send(6'b000010, 32, 1'b0, 16);
        chk_ptrs();
        chk("t3 err0 after", 32'(err0), 32'd0);
        rd_chk("t3 ch1 lo", 1'b0, 1, 0, 16'h5678);
        rd_chk("t3 ch1 hi", 1'b0, 1, 1, 16'h1234);

        // Five words on channel 3 wrap the 4-deep buffer of dut1.
        for (int w = 1; w <= 5; w++) begin
            tx_word[3] = 32'(w);
            send(6'b001000, 32, 1'b0, 16);
        end
        chk_ptrs();
        chk("t4 dut1 ptr ch3", 32'(wr_ptr1[7:6]), 32'd1);
        chk("t4 dut0 ptr ch3", 32'(wr_ptr0[15:12]), 32'd3);
        chk("t4 err0 par", 32'(err0), ef(3, 3'b001));
        chk("t4 err1 par", 32'(err1), ef(3, 3'b001));
        clr(6'b001000);
        rd_chk("t4 dut1 e0", 1'b1, 3, 0, 16'h0005);
        rd_chk("t4 dut1 e1", 1'b1, 3, 2, 16'h0002);
        rd_chk("t4 dut1 e2", 1'b1, 3, 4, 16'h0003);
        rd_chk("t4 dut1 e3", 1'b1, 3, 6, 16'h0004);
        rd_chk("t4 dut1 e3 hi", 1'b1, 3, 7, 16'h0000);
        rd_chk("t4 dut0 e2", 1'b0, 3, 4, 16'h0004);
        rd_chk("t4 bad ch", 1'b0, 7, 4, 16'h0000);

        // Illegal line state at bit 10 on channel 4.
        tx_word[4] = 32'h0000_0155;
        send(6'b010000, 10, 1'b1, 16);
        chk("t5 err0 ill", 32'(err0), ef(4, 3'b100));
        chk("t5 err1 ill", 32'(err1), ef(4, 3'b100));
        chk_ptrs();

        // All six channels at once with distinct words.
        tx_word[0] = 32'h0000_0001;
        tx_word[1] = 32'h0000_0002;
        tx_word[2] = 32'h0000_0004;
        tx_word[3] = 32'h0000_0008;
        tx_word[4] = 32'h0000_0010;
        tx_word[5] = 32'h8000_0000;
        send(6'b111111, 32, 1'b0, 16);
        chk_ptrs();
        chk("t6 err0", 32'(err0), ef(4, 3'b100));
        rd_chk("t6 ch5 hi", 1'b0, 5, 1, 16'h8000);
        rd_chk("t6 ch4 lo", 1'b0, 4, 0, 16'h0010);
        rd_chk("t6 ch2 lo", 1'b0, 2, 0, 16'h0004);
        rd_chk("t6 ch3 e3", 1'b0, 3, 6, 16'h0008);
        rd_chk("t6 dut1 ch0 e1", 1'b1, 0, 2, 16'h0001);
        rd_chk("t6 dut1 ch3 e1", 1'b1, 3, 2, 16'h0008);

        // Reset in the middle of a word on channel 0.
        rd_chk("t7 pre ch0 lo", 1'b0, 0, 0, 16'h00A5);
        tx_word[0] = 32'hFFFF_FFFF;
        send(6'b000001, 16, 1'b0, 0);
        #4;
        reset = 1'b1;
        #2;
        chk("t7 rd_data0", 32'(rd_data0), 32'd0);
        chk("t7 wr_ptr0", 32'(wr_ptr0), 32'd0);
        chk("t7 err0", 32'(err0), 32'd0);
        chk("t7 strb0", 32'(strb0), 32'd0);
        chk("t7 wr_ptr1", 32'(wr_ptr1), 32'd0);
        chk("t7 q0 drained", 32'(q0.size()), 32'd0);
        chk("t7 q1 drained", 32'(q1.size()), 32'd0);
        #4;
        reset = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            exp_ptr0[c] = 0;
            exp_ptr1[c] = 0;
        end
        drive(6'd0, 6'd0, 4);
        tx_word[0] = 32'h0000_0007;
        send(6'b000001, 32, 1'b0, 16);
        chk_ptrs();
        rd_chk("t7 ch0 lo", 1'b0, 0, 0, 16'h0007);
        rd_chk("t7 dut1 ch0 lo", 1'b1, 0, 0, 16'h0007);
        chk("end q0 drained", 32'(q0.size()), 32'd0);
        chk("end q1 drained", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/rz_rx_multi.md
Name: rz_rx_multi

Overview:
- Parametrised N-channel ARINC429 (RZ bipolar) receiver and word store.
- Per channel: line decoding, debounce, word assembly, parity and length checking, and a circular word buffer of DEPTH 32-bit words.
- All buffers share one 16-bit read port selected by channel and half-word address.
- Sits between the line receivers and the host read mux, in place of fixed 6-channel receiver banks.

Parameters:
- NUM_CH, 6, number of ARINC channels (1..16).
- DEPTH, 16, 32-bit words per channel buffer (power of 2, 4..256).
- DEB, 2, consecutive identical non-null samples required to accept a bit (1..4).
- GAP, 12, consecutive NULL samples that close a word.
- STORE_BAD, 0, 1 = store words with parity error; 0 = discard them.

Ports:
- clock  in  1  system clock (<= 400 kHz domain master clock).
- reset  in  1  asynchronous, active-high reset.
- inp_clk  in  1  sample strobe; each rising edge (detected in the clock domain) is one sample tick.
- line_A  in  NUM_CH  ARINC A leg per channel.
- line_B  in  NUM_CH  ARINC B leg per channel.
- rd_ch  in  max(1,clog2(NUM_CH))  read channel select.
- rd_addr  in  clog2(DEPTH)+1  half-word address; LSB=0 low 16 bits, LSB=1 high 16 bits.
- rd_data  out  16  read data.
- wr_ptr  out  NUM_CH*clog2(DEPTH)  per-channel next write index.
- word_strb  out  NUM_CH  one-cycle pulse per stored word.
- err_flags  out  NUM_CH*3  sticky per channel: [0] parity, [1] length, [2] illegal line state.
- err_clr  in  NUM_CH  per-channel synchronous clear of err_flags.

Behaviour:
- Reset (asynchronous, active-high) clears:
  - rd_data, wr_ptr, word_strb, err_flags, bit counters, debounce and gap counters → 0;
  - every channel decoder → IDLE.
  - Buffer RAM is not cleared.
- Input conditioning:
  - line_A, line_B and inp_clk each pass through a 2-FF synchronizer.
  - A tick is the clock cycle following a synchronized 0→1 transition of inp_clk.
- Line state, sampled on each tick:
  - A=1,B=0 → ONE; A=0,B=1 → ZERO; A=0,B=0 → NULL; A=1,B=1 → ILLEGAL.
- Bit acceptance:
  - A bit is accepted when DEB consecutive ticks show the same ONE/ZERO after at least one NULL tick.
  - The bit value is written into word[bit_cnt]; the first bit received is bit 0 (label LSB).
  - Exactly one bit is accepted per NULL-separated pulse.
- Decoder states:
  - IDLE → RX on the first accepted bit.
  - RX → CHECK when bit_cnt reaches 32.
  - RX → IDLE, setting err[1], when GAP NULL ticks occur with 1..31 bits received; the word is discarded.
  - CHECK → WAIT_GAP after one clock.
  - WAIT_GAP → IDLE after GAP NULL ticks.
  - A bit accepted in WAIT_GAP sets err[1] and is ignored.
  - An ILLEGAL tick in any state except IDLE sets err[2], discards the word and enters WAIT_GAP.
  - ILLEGAL in IDLE sets err[2] only.
- CHECK:
  - Odd parity over all 32 bits is required; even parity sets err[0].
  - A word is written to buffer[wr_ptr] if parity is good or STORE_BAD=1.
  - On a write: word_strb pulses in the same cycle, and wr_ptr increments on the following clock edge.
  - The write happens 1 clock after the clock in which the 32nd bit is accepted.
- Wrap-around: wr_ptr wraps DEPTH-1 → 0 and overwrites the oldest word; there is no full or overflow flag.
- Read port:
  - Registered, 1-cycle latency: rd_data(n+1) = buffer[rd_ch][rd_addr>>1] half-select(rd_addr[0]) sampled at n.
  - rd_ch >= NUM_CH returns 0.
  - A read and a write to the same entry in the same cycle return the old data.
- Errors:
  - err_flags bits are sticky until err_clr[ch] is asserted.
  - If err_clr and a new error coincide in the same cycle, the new error wins (flag stays set).
- Reset mid-word: the partial word is lost, no strobe is issued, and the decoder restarts in IDLE.

Decomposition:
- Package rz_pkg:
  - line-state enum (NULL/ONE/ZERO/ILLEGAL);
  - decoder state enum (IDLE/RX/CHECK/WAIT_GAP);
  - error bit index constants ERR_PAR=0, ERR_LEN=1, ERR_ILL=2;
  - WORD_BITS=32.
- Sub-module rz_rx_chan: one channel.
  - Contents: synchronizers, debounce, decoder FSM, parity check, error flags, DEPTH×32 buffer with write pointer.
  - Exposes a read address/data port.
- Top: tick detect, generate loop over NUM_CH, registered read mux.

Test Plan:
- Channel 0 sends 0x8000_00A5 (odd parity) at 4 ticks/bit with a 16-tick gap → word_strb[0] one pulse, wr_ptr[0]=1, reads at rd_addr=0/1 → 0x00A5/0x8000, err_flags=0.
- Channel 2 sends 0x0000_00A5 (even parity), STORE_BAD=0 → no strobe, wr_ptr unchanged, err[0]=1; pulse err_clr[2] → 0. Repeat with STORE_BAD=1 → word stored, err[0]=1.
- Channel 1 sends 20 bits then a 16-tick gap → err[1]=1, no strobe; the next valid word stores correctly at index 0.
- DEPTH=4: send 5 words 1..5 on channel 3 → wr_ptr=1; entry 0 holds word 5, entries 1..3 hold words 2..4.
- A=B=1 for 2 ticks at bit 10 → err[2]=1, word discarded; with all 6 channels sending simultaneously, each channel stores its own word with no cross-talk.
- Assert reset at bit 16 → all outputs 0 immediately (asynchronous); after release, a full word stores at index 0.
